// File: rtl/tc_pl_acptx_pkg.sv
// tc_pl_acptx_pkg: shared FSM encoding and CRC-32 constants for the capture-to-ACP transmitter
package tc_pl_acptx_pkg;
   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_t;
   localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
   localparam int PAGE_BYTES = 4096;
endpackage

// File: rtl/tc_pl_crc32_dw.sv
// tc_pl_crc32_dw: next-state CRC-32 (reflected) over a DW-bit beat, bytes taken little-endian
module tc_pl_crc32_dw
   import tc_pl_acptx_pkg::*;
#(
   parameter int DW = 64
)(
   input  logic [31:0]   crc_in,
   input  logic [DW-1:0] data,
   output logic [31:0]   crc_out
);
   logic [31:0] c;
   always_comb begin
      c = crc_in;
      for (int i = 0; i < DW; i++)
         c = (c >> 1) ^ ((c[0] ^ data[i]) ? CRC32_POLY_R : 32'h0);
      crc_out = c;
   end
endmodule

// File: rtl/tc_pl_cap_acptx_burst.sv
// tc_pl_cap_acptx_burst: drains a FWFT capture FIFO into DDR as 4 KB-safe ACP bursts with running CRC-32
module tc_pl_cap_acptx_burst
   import tc_pl_acptx_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int CRC_W     = 32,
   parameter int BUF_W     = 128,
   parameter int DW        = 64,
   parameter int BURST_LEN = 16,
   parameter int LEN_W     = 24,
   parameter int ID_W      = 3,
   parameter int AWID      = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              tacp_en,
   output logic              tacp_cmpt,
   output logic              tacp_busy,
   output logic              tacp_err,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [LEN_W-1:0]  cap_len,
   output logic [CRC_W-1:0]  cap_crc32,
   input  logic              buff_empty,
   input  logic [BUF_W-1:0]  buff_dout,
   output logic              buff_dout_req,
   output logic              acp_tx_en,
   input  logic              acp_tx_rdy,
   output logic [ADDR_W-1:0] acp_tx_awaddr,
   output logic [ID_W-1:0]   acp_tx_awid,
   output logic [7:0]        acp_tx_awlen,
   output logic [DW-1:0]     acp_tx_wdata,
   input  logic              acp_tx_wdreq
);
   localparam int R    = BUF_W / DW;
   localparam int SL_W = (R > 1) ? $clog2(R) : 1;
   localparam int RB_W = LEN_W + $clog2(R);
   localparam int BS   = $clog2(DW / 8);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [RB_W-1:0]   rem_beats, page_beats, lim, blen_c;
   logic [8:0]        blen, beat;
   logic [SL_W-1:0]   slice;
   logic [31:0]       crc, crc_next;
   logic              last_slice, last_beat, beat_go;

   assign acp_tx_awid   = ID_W'(AWID);
   assign last_slice    = slice == SL_W'(R - 1);
   assign last_beat     = beat == blen - 9'd1;
   assign beat_go       = state == S_DATA && acp_tx_wdreq;
   assign acp_tx_wdata  = (state == S_DATA && !buff_empty) ? buff_dout[slice*DW +: DW] : '0;
   // pop is same-cycle with the last slice; gated by rst so a reset edge never consumes a word
   assign buff_dout_req = !rst && beat_go && last_slice && !buff_empty;

   always_comb begin
      page_beats = RB_W'((13'(PAGE_BYTES) - {1'b0, addr[11:0]}) >> BS);
      lim        = (page_beats < RB_W'(BURST_LEN)) ? page_beats : RB_W'(BURST_LEN);
      blen_c     = (rem_beats < lim) ? rem_beats : lim;
   end

   tc_pl_crc32_dw #(.DW(DW)) u_crc (.crc_in(crc), .data(acp_tx_wdata), .crc_out(crc_next));

   always_ff @(posedge clk)
      if (rst) begin
         state         <= S_IDLE;
         addr          <= '0;
         rem_beats     <= '0;
         blen          <= '0;
         beat          <= '0;
         slice         <= '0;
         crc           <= '0;
         tacp_cmpt     <= 1'b0;
         tacp_busy     <= 1'b0;
         tacp_err      <= 1'b0;
         cap_crc32     <= '0;
         acp_tx_en     <= 1'b0;
         acp_tx_awaddr <= '0;
         acp_tx_awlen  <= '0;
      end else
         case (state)
            S_IDLE: if (tacp_en) begin
               addr      <= cap_addr & ~ADDR_W'((1 << BS) - 1);
               rem_beats <= RB_W'(cap_len) * RB_W'(R);
               slice     <= '0;
               crc       <= CRC32_INIT;
               tacp_err  <= 1'b0;
               tacp_busy <= 1'b1;
               state     <= S_CALC;
            end
            S_CALC: if (rem_beats == '0) begin
               cap_crc32 <= crc ^ CRC32_XOROUT;
               tacp_cmpt <= 1'b1;
               tacp_busy <= 1'b0;
               state     <= S_DONE;
            end else if (!buff_empty) begin
               blen          <= 9'(blen_c);
               acp_tx_awaddr <= addr;
               acp_tx_awlen  <= 8'(blen_c) - 8'd1;
               acp_tx_en     <= 1'b1;
               state         <= S_ADDR;
            end
            S_ADDR: if (acp_tx_rdy) begin
               acp_tx_en <= 1'b0;
               beat      <= '0;
               state     <= S_DATA;
            end
            S_DATA: if (acp_tx_wdreq) begin
               slice <= last_slice ? '0 : slice + 1'b1;
               crc   <= crc_next;
               beat  <= beat + 9'd1;
               if (buff_empty) tacp_err <= 1'b1;
               if (last_beat) begin
                  addr      <= addr + (ADDR_W'(blen) << BS);
                  rem_beats <= rem_beats - RB_W'(blen);
                  if (rem_beats == RB_W'(blen)) begin
                     cap_crc32 <= crc_next ^ CRC32_XOROUT;
                     tacp_cmpt <= 1'b1;
                     tacp_busy <= 1'b0;
                     state     <= S_DONE;
                  end else
                     state <= S_CALC;
               end
            end
            S_DONE: if (!tacp_en) begin
               tacp_cmpt <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
endmodule

// File: tb/tb_tc_pl_cap_acptx_burst.sv
// tb_tc_pl_cap_acptx_burst: directed scenarios with a FIFO model, burst/beat scoreboard and software CRC-32
module tb_tc_pl_cap_acptx_burst;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         tacp_en = 1'b0;
   logic         tacp_cmpt, tacp_busy, tacp_err;
   logic [31:0]  cap_addr = '0;
   logic [23:0]  cap_len = '0;
   logic [31:0]  cap_crc32;
   logic         buff_empty;
   logic [127:0] buff_dout;
   logic         buff_dout_req;
   logic         acp_tx_en;
   logic         acp_tx_rdy = 1'b1;
   logic [31:0]  acp_tx_awaddr;
   logic [2:0]   acp_tx_awid;
   logic [7:0]   acp_tx_awlen;
   logic [63:0]  acp_tx_wdata;
   logic         acp_tx_wdreq = 1'b1;

   tc_pl_cap_acptx_burst dut (
      .clk(clk), .rst(rst), .tacp_en(tacp_en), .tacp_cmpt(tacp_cmpt), .tacp_busy(tacp_busy),
      .tacp_err(tacp_err), .cap_addr(cap_addr), .cap_len(cap_len), .cap_crc32(cap_crc32),
      .buff_empty(buff_empty), .buff_dout(buff_dout), .buff_dout_req(buff_dout_req),
      .acp_tx_en(acp_tx_en), .acp_tx_rdy(acp_tx_rdy), .acp_tx_awaddr(acp_tx_awaddr),
      .acp_tx_awid(acp_tx_awid), .acp_tx_awlen(acp_tx_awlen), .acp_tx_wdata(acp_tx_wdata),
      .acp_tx_wdreq(acp_tx_wdreq)
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] a; logic [7:0] l;} burst_t;
   burst_t      exp_bursts[$];
   logic [63:0] exp_beats[$];
   burst_t      e_b;
   int          nvec = 0, nerr = 0;
   int          beats_left = 0, beats_seen = 0, npops = 0, exp_pops = 0;
   bit          stall_en = 1'b0, flush = 1'b0, exp_err;
   logic [31:0] exp_crc;
   logic [127:0] mem [256];
   logic [7:0]  rd = '0, wr = '0, rd_before;

   // FWFT FIFO model: head word visible combinationally, pop takes effect on the clock edge
   assign buff_empty = rd == wr;
   assign buff_dout  = mem[rd];
   always @(posedge clk)
      if (flush) rd <= wr;
      else if (buff_dout_req) rd <= rd + 8'd1;

   initial forever begin
      @(posedge clk); #1;
      acp_tx_wdreq = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      acp_tx_rdy   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      c = c ^ {24'h0, d};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // negedge monitor: what is seen here is what the DUT samples at the next posedge
   always @(negedge clk)
      if (rst) beats_left = 0;
      else begin
         if (acp_tx_en && acp_tx_rdy) begin
            chk("burst_pending", 128'(exp_bursts.size() > 0), 1);
            if (exp_bursts.size() > 0) begin
               e_b = exp_bursts.pop_front();
               chk("awaddr", acp_tx_awaddr, e_b.a);
               chk("awlen", acp_tx_awlen, e_b.l);
            end
            chk("no_4k_cross", 128'(int'(acp_tx_awaddr[11:0]) + (int'(acp_tx_awlen) + 1) * 8 <= 4096), 1);
            beats_left = int'(acp_tx_awlen) + 1;
         end else if (beats_left > 0 && acp_tx_wdreq) begin
            chk("beat_pending", 128'(exp_beats.size() > 0), 1);
            if (exp_beats.size() > 0) chk("wdata", acp_tx_wdata, exp_beats.pop_front());
            beats_left--;
            beats_seen++;
         end
         if (buff_dout_req) npops++;
      end

   task automatic start(input logic [31:0] a, input int len, input int avail, input bit stall);
      logic [31:0] ad = a & ~32'h7;
      logic [31:0] c = 32'hFFFFFFFF;
      logic [127:0] w;
      logic [63:0] b;
      int rem = len * 2, bl, pg;
      exp_beats.delete();
      exp_bursts.delete();
      npops = 0;
      beats_seen = 0;
      stall_en = stall;
      for (int i = 0; i < len; i++) begin
         w = '0;
         if (i < avail) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem[wr] = w;
            wr = wr + 8'd1;
         end
         for (int s = 0; s < 2; s++) begin
            b = w[s*64 +: 64];
            exp_beats.push_back(b);
            for (int k = 0; k < 8; k++) c = crc_byte(c, b[k*8 +: 8]);
         end
      end
      while (rem > 0) begin
         bl = (rem < 16) ? rem : 16;
         pg = (4096 - int'(ad[11:0])) / 8;
         if (pg < bl) bl = pg;
         exp_bursts.push_back('{ad, 8'(bl - 1)});
         ad = ad + 32'(bl * 8);
         rem = rem - bl;
      end
      exp_crc  = ~c;
      exp_err  = avail < len;
      exp_pops = (avail < len) ? avail : len;
      tacp_en  = 1'b1;
      cap_addr = a;
      cap_len  = 24'(len);
   endtask

   task automatic finish(input int len, input bit drop);
      int cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) begin cap_addr = 32'hDEADBEE8; cap_len = 24'd7; end
         if (drop && cyc == 4) tacp_en = 1'b0;
      end while (!tacp_cmpt && cyc < 3000);
      chk("cmpt", tacp_cmpt, 1);
      if (len == 0) chk("cmpt_latency", cyc, 2);
      chk("busy_done", tacp_busy, 0);
      chk("crc32", cap_crc32, exp_crc);
      chk("err", tacp_err, exp_err);
      chk("pops", npops, exp_pops);
      chk("beats_left_over", exp_beats.size(), 0);
      chk("bursts_left_over", exp_bursts.size(), 0);
      if (!drop) begin
         @(posedge clk); #1;
         chk("cmpt_hold", tacp_cmpt, 1);
         tacp_en = 1'b0;
      end
      @(posedge clk); #1;
      chk("cmpt_clear", tacp_cmpt, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {tacp_cmpt, tacp_busy, tacp_err, cap_crc32, acp_tx_en, acp_tx_awaddr, acp_tx_awlen, buff_dout_req}, 0);
      chk("rst_wdata", acp_tx_wdata, 0);
      chk("awid", acp_tx_awid, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      start(32'h1000_0000, 4, 4, 1'b0);  finish(4, 1'b0);
      start(32'h0000_0000, 20, 20, 1'b1); finish(20, 1'b0);
      start(32'h0000_0FC0, 8, 8, 1'b0);  finish(8, 1'b0);
      start(32'h0000_0FF8, 2, 2, 1'b1);  finish(2, 1'b0);
      start(32'h0000_0000, 0, 0, 1'b0);  finish(0, 1'b0);
      start(32'h0000_2000, 4, 1, 1'b0);  finish(4, 1'b0);
      start(32'h0000_3000, 4, 4, 1'b0);  finish(4, 1'b0);
      start(32'h0000_5000, 20, 20, 1'b1); finish(20, 1'b1);
      start(32'h0000_0000, 20, 20, 1'b0);
      for (int i = 0; i < 200 && beats_seen < 3; i++) begin @(posedge clk); #1; end
      chk("reached_data", 128'(beats_seen >= 3), 1);
      rst = 1'b1;
      rd_before = rd;
      @(posedge clk); #1;
      chk("mid_rst_outs", {tacp_cmpt, tacp_busy, tacp_err, cap_crc32, acp_tx_en, acp_tx_awaddr, acp_tx_awlen, buff_dout_req}, 0);
      chk("mid_rst_wdata", acp_tx_wdata, 0);
      chk("mid_rst_no_pop", rd, rd_before);
      rst = 1'b0;
      tacp_en = 1'b0;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      exp_beats.delete();
      exp_bursts.delete();
      start(32'h0000_0045, 3, 3, 1'b1);  finish(3, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
